// File: rtl/traffic_pkg.sv
// Shared codes for the traffic light system: lamp states, modes, engine
// enables and the mode-sequencer FSM encoding.
package traffic_pkg;

  localparam logic [2:0] ST_OFF    = 3'd0;
  localparam logic [2:0] ST_ALLRED = 3'd2;
  localparam logic [2:0] ST_GR     = 3'd3;
  localparam logic [2:0] ST_YR     = 3'd4;
  localparam logic [2:0] ST_RG     = 3'd5;
  localparam logic [2:0] ST_RY     = 3'd6;
  localparam logic [2:0] ST_FLASH  = 3'd7;

  localparam logic [1:0] MODE_NONE   = 2'b00;
  localparam logic [1:0] MODE_AUTO   = 2'b01;
  localparam logic [1:0] MODE_MANUAL = 2'b10;
  localparam logic [1:0] MODE_NIGHT  = 2'b11;

  localparam logic [2:0] EN_NONE   = 3'b000;
  localparam logic [2:0] EN_MANUAL = 3'b001;
  localparam logic [2:0] EN_AUTO   = 3'b010;
  localparam logic [2:0] EN_NIGHT  = 3'b100;

  typedef enum logic [1:0] {
    SEQ_CLEAR     = 2'd0,
    SEQ_RUN       = 2'd1,
    SEQ_WAIT_SAFE = 2'd2
  } seq_state_e;

  // One-hot engine select for a mode; unknown modes select nothing.
  function automatic logic [2:0] mode_enable(input logic [1:0] m);
    case (m)
      MODE_AUTO:   return EN_AUTO;
      MODE_MANUAL: return EN_MANUAL;
      MODE_NIGHT:  return EN_NIGHT;
      default:     return EN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/traffic_mode_sequencer_flash_gen.sv
// Night flash pattern: FLASH_HALF cycles at FLASH, FLASH_HALF cycles at OFF.
// restart forces the pattern back to the start of a FLASH half-period.
module flash_gen
  import traffic_pkg::*;
#(
  parameter int FLASH_HALF = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart,
  output logic [2:0] level
);

  logic [15:0] cnt;
  logic        lit;

  // Half-period counter; flips the lamp level every FLASH_HALF cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      lit <= 1'b1;
    end else if (restart) begin
      cnt <= '0;
      lit <= 1'b1;
    end else if (cnt == 16'(FLASH_HALF - 1)) begin
      cnt <= '0;
      lit <= ~lit;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  assign level = lit ? ST_FLASH : ST_OFF;

endmodule

// File: rtl/traffic_mode_sequencer.sv
// Mode controller: picks which engine owns the lights, switching only at
// safe points and always through an all-red clearance interval.
module traffic_mode_sequencer
  import traffic_pkg::*;
#(
  parameter int         FLASH_HALF   = 8,
  parameter int         SAFE_TIMEOUT = 127,
  parameter logic [1:0] RESET_MODE   = 2'b01
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] modeReq,
  input  logic       modeReqValid,
  input  logic [6:0] clearTime,
  input  logic [2:0] autoState,
  input  logic [2:0] manualState,
  output logic [2:0] enable,
  output logic [2:0] state,
  output logic [1:0] mode,
  output logic       busy
);

  seq_state_e seq_q, seq_d;
  logic [1:0] target_q, target_d;
  logic [1:0] mode_q, mode_d;
  logic [2:0] enable_q, enable_d;
  logic       busy_d;
  logic       pend_vld_q, pend_vld_d;
  logic [1:0] pend_q, pend_d;
  // cnt_q == 0 only after reset: the first CLEAR cycle samples clearTime.
  logic [6:0] cnt_q, cnt_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic       flash_restart;
  logic [2:0] flash_level;
  logic       req_ok;
  logic [6:0] clear_len, clear_cur;
  logic [2:0] eng_state;

  flash_gen #(.FLASH_HALF(FLASH_HALF)) u_flash (
    .clk     (clk),
    .rst     (reset),
    .restart (flash_restart),
    .level   (flash_level)
  );

  assign clear_len = (clearTime == 7'd0) ? 7'd1 : clearTime;
  assign clear_cur = (cnt_q == 7'd0) ? clear_len : cnt_q;
  assign eng_state = (mode_q == MODE_AUTO) ? autoState : manualState;
  // During clearance every non-null request is kept; elsewhere a request
  // for the already-active mode with nothing queued is meaningless.
  assign req_ok = modeReqValid && (modeReq != MODE_NONE) &&
                  ((seq_q == SEQ_CLEAR) || pend_vld_q || (modeReq != mode_q));

  // Next-state and registered-output decode.
  always_comb begin
    seq_d         = seq_q;
    target_d      = target_q;
    mode_d        = mode_q;
    enable_d      = enable_q;
    pend_vld_d    = pend_vld_q;
    pend_d        = pend_q;
    cnt_d         = cnt_q;
    tcnt_d        = tcnt_q;
    flash_restart = 1'b0;
    case (seq_q)
      SEQ_CLEAR: begin
        if (clear_cur == 7'd1) begin
          seq_d         = SEQ_RUN;
          mode_d        = target_q;
          enable_d      = mode_enable(target_q);
          flash_restart = (target_q == MODE_NIGHT);
        end else begin
          cnt_d = clear_cur - 7'd1;
        end
      end
      SEQ_RUN: begin
        if (pend_vld_q) begin
          if (pend_q == mode_q) begin
            pend_vld_d = 1'b0;
          end else if (mode_q == MODE_NIGHT) begin
            seq_d      = SEQ_CLEAR;
            target_d   = pend_q;
            pend_vld_d = 1'b0;
            cnt_d      = clear_len;
            enable_d   = EN_NONE;
          end else begin
            seq_d  = SEQ_WAIT_SAFE;
            tcnt_d = 8'd0;
          end
        end
      end
      SEQ_WAIT_SAFE: begin
        if (eng_state == ST_GR || eng_state == ST_RG ||
            tcnt_q == 8'(SAFE_TIMEOUT)) begin
          seq_d      = SEQ_CLEAR;
          target_d   = pend_q;
          pend_vld_d = 1'b0;
          cnt_d      = clear_len;
          enable_d   = EN_NONE;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      default: seq_d = SEQ_CLEAR;
    endcase
    // A new request overrides anything consumed on the same edge.
    if (req_ok) begin
      pend_vld_d = 1'b1;
      pend_d     = modeReq;
    end
    busy_d = pend_vld_d || (seq_d != SEQ_RUN);
  end

  // Sequencer registers; reset restarts clearance toward RESET_MODE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_q      <= SEQ_CLEAR;
      target_q   <= RESET_MODE;
      mode_q     <= RESET_MODE;
      enable_q   <= EN_NONE;
      busy       <= 1'b1;
      pend_vld_q <= 1'b0;
      pend_q     <= MODE_NONE;
      cnt_q      <= 7'd0;
      tcnt_q     <= 8'd0;
    end else begin
      seq_q      <= seq_d;
      target_q   <= target_d;
      mode_q     <= mode_d;
      enable_q   <= enable_d;
      busy       <= busy_d;
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      tcnt_q     <= tcnt_d;
    end
  end

  // Light-state mux: all-red in clearance, else the owning engine.
  always_comb begin
    state = ST_ALLRED;
    if (seq_q != SEQ_CLEAR) begin
      case (mode_q)
        MODE_AUTO:   state = autoState;
        MODE_MANUAL: state = manualState;
        MODE_NIGHT:  state = flash_level;
        default:     state = ST_OFF;
      endcase
    end
  end

  assign enable = enable_q;
  assign mode   = mode_q;

endmodule

// File: tb/tb_traffic_mode_sequencer.sv
// Scenario bench for traffic_mode_sequencer with randomized clearance
// lengths, dwell times and engine states.
module tb_traffic_mode_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] modeReq;
  logic       modeReqValid;
  logic [6:0] clearTime;
  logic [2:0] autoState;
  logic [2:0] manualState;
  logic [2:0] enable;
  logic [2:0] state;
  logic [1:0] mode;
  logic       busy;

  int errors = 0;
  int checks = 0;
  logic [8:0] exp9;
  logic [2:0] unsafe_codes [5] = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd7};

  traffic_mode_sequencer #(
    .FLASH_HALF   (8),
    .SAFE_TIMEOUT (127),
    .RESET_MODE   (2'b01)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .modeReq      (modeReq),
    .modeReqValid (modeReqValid),
    .clearTime    (clearTime),
    .autoState    (autoState),
    .manualState  (manualState),
    .enable       (enable),
    .state        (state),
    .mode         (mode),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Engine select expected for a mode.
  function automatic logic [2:0] onehot(input logic [1:0] m);
    if (m == 2'b01) return 3'b010;
    if (m == 2'b10) return 3'b001;
    if (m == 2'b11) return 3'b100;
    return 3'b000;
  endfunction

  // Night pattern level i cycles after entering night.
  function automatic logic [2:0] flash_at(input int i);
    return ((i / 8) % 2 == 0) ? 3'd7 : 3'd0;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; modeReq = 2'b00; modeReqValid = 1'b0;
    clearTime = 7'd5; autoState = 3'd4; manualState = 3'd6;
    step; step;
    #1; checks++; exp9 = {3'b000, 3'd2, 2'b01, 1'b1};
    if ({enable, state, mode, busy} !== exp9) begin
      errors++; $display("FAIL reset_hold got=%b want=%b", {enable, state, mode, busy}, exp9);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1; checks++; exp9 = {3'b000, 3'd2, 2'b01, 1'b1};
      if ({enable, state, mode, busy} !== exp9) begin
        errors++; $display("FAIL reset_clear[%0d] got=%b want=%b", i, {enable, state, mode, busy}, exp9);
      end
      step;
    end
    #1; checks++; exp9 = {onehot(2'b01), autoState, 2'b01, 1'b0};
    if ({enable, state, mode, busy} !== exp9) begin
      errors++; $display("FAIL reset_run got=%b want=%b", {enable, state, mode, busy}, exp9);
    end
  endtask

  // Auto -> manual: holds the auto engine until it reports a safe state.
  task automatic test_safe_point;
    int ct, k;
    ct = 1 + int'($urandom_range(0, 7));
    k  = 1 + int'($urandom_range(0, 19));
    clearTime = 7'(ct); autoState = 3'd4; manualState = 3'd6;
    modeReq = 2'b10; modeReqValid = 1'b1;
    step;
    modeReqValid = 1'b0;
    #1; checks++; exp9 = {3'b010, 3'd4, 2'b01, 1'b1};
    if ({enable, state, mode, busy} !== exp9) begin
      errors++; $display("FAIL safe_latch got=%b want=%b", {enable, state, mode, busy}, exp9);
    end
    step;
    for (int i = 0; i < k; i++) begin
      autoState = unsafe_codes[$urandom_range(0, 4)];
      #1; checks++; exp9 = {3'b010, autoState, 2'b01, 1'b1};
      if ({enable, state, mode, busy} !== exp9) begin
        errors++; $display("FAIL safe_wait[%0d] got=%b want=%b", i, {enable, state, mode, busy}, exp9);
      end
      step;
    end
    autoState = 3'd5;
    step;
    for (int i = 0; i < ct; i++) begin
      #1; checks++; exp9 = {3'b000, 3'd2, 2'b01, 1'b1};
      if ({enable, state, mode, busy} !== exp9) begin
        errors++; $display("FAIL safe_clear[%0d] got=%b want=%b", i, {enable, state, mode, busy}, exp9);
      end
      step;
    end
    #1; checks++; exp9 = {onehot(2'b10), manualState, 2'b10, 1'b0};
    if ({enable, state, mode, busy} !== exp9) begin
      errors++; $display("FAIL safe_run got=%b want=%b", {enable, state, mode, busy}, exp9);
    end
  endtask

  // Manual engine never safe: forced exit after SAFE_TIMEOUT+1 cycles.
  task automatic test_timeout;
    int n;
    clearTime = 7'd0; manualState = 3'd6;
    modeReq = 2'b11; modeReqValid = 1'b1;
    step;
    modeReqValid = 1'b0;
    step;
    n = 0;
    #1;
    while (state != 3'd2 && n < 300) begin
      if (enable !== 3'b001) begin
        errors++; checks++; $display("FAIL timeout_enable[%0d] got=%b want=001", n, enable);
      end
      n++;
      step;
    end
    checks++;
    if (n !== 128) begin
      errors++; $display("FAIL timeout_len got=%0d want=128", n);
    end
    checks++; exp9 = {3'b000, 3'd2, 2'b10, 1'b1};
    if ({enable, state, mode, busy} !== exp9) begin
      errors++; $display("FAIL timeout_clear got=%b want=%b", {enable, state, mode, busy}, exp9);
    end
    step;
    #1; checks++; exp9 = {onehot(2'b11), 3'd7, 2'b11, 1'b0};
    if ({enable, state, mode, busy} !== exp9) begin
      errors++; $display("FAIL timeout_night got=%b want=%b", {enable, state, mode, busy}, exp9);
    end
  endtask

  // Night flashing; a request for night while in night is dropped.
  task automatic test_night_flash;
    for (int i = 0; i < 24; i++) begin
      if (i == 3) begin modeReq = 2'b11; modeReqValid = 1'b1; end
      if (i == 4) modeReqValid = 1'b0;
      #1; checks++; exp9 = {3'b100, flash_at(i), 2'b11, 1'b0};
      if ({enable, state, mode, busy} !== exp9) begin
        errors++; $display("FAIL flash[%0d] got=%b want=%b", i, {enable, state, mode, busy}, exp9);
      end
      step;
    end
  endtask

  // Night -> auto: CLEAR at t+2, new enable at t+2+clearTime.
  task automatic test_night_exit;
    int ct;
    ct = 1 + int'($urandom_range(0, 5));
    clearTime = 7'(ct); autoState = 3'd4;
    modeReq = 2'b01; modeReqValid = 1'b1;
    step;
    modeReqValid = 1'b0;
    #1; checks++;
    if ({enable, mode, busy} !== {3'b100, 2'b11, 1'b1}) begin
      errors++; $display("FAIL nexit_latch got=%b want=%b", {enable, mode, busy}, {3'b100, 2'b11, 1'b1});
    end
    step;
    for (int i = 0; i < ct; i++) begin
      #1; checks++; exp9 = {3'b000, 3'd2, 2'b11, 1'b1};
      if ({enable, state, mode, busy} !== exp9) begin
        errors++; $display("FAIL nexit_clear[%0d] got=%b want=%b", i, {enable, state, mode, busy}, exp9);
      end
      step;
    end
    #1; checks++; exp9 = {3'b010, 3'd4, 2'b01, 1'b0};
    if ({enable, state, mode, busy} !== exp9) begin
      errors++; $display("FAIL nexit_run got=%b want=%b", {enable, state, mode, busy}, exp9);
    end
  endtask

  // Auto -> night, with requests arriving during clearance.
  task automatic test_back_to_back;
    int ct;
    ct = 2 + int'($urandom_range(0, 4));
    clearTime = 7'(ct); autoState = 3'd3;
    modeReq = 2'b11; modeReqValid = 1'b1;
    step;
    modeReqValid = 1'b0;
    step;
    #1; checks++; exp9 = {3'b010, 3'd3, 2'b01, 1'b1};
    if ({enable, state, mode, busy} !== exp9) begin
      errors++; $display("FAIL b2b_wait got=%b want=%b", {enable, state, mode, busy}, exp9);
    end
    step;
    for (int i = 0; i < ct; i++) begin
      if (i == 0) begin modeReq = 2'b01; modeReqValid = 1'b1; end
      if (i == 1) modeReqValid = 1'b0;
      #1; checks++; exp9 = {3'b000, 3'd2, 2'b01, 1'b1};
      if ({enable, state, mode, busy} !== exp9) begin
        errors++; $display("FAIL b2b_clear1[%0d] got=%b want=%b", i, {enable, state, mode, busy}, exp9);
      end
      step;
    end
    #1; checks++; exp9 = {3'b100, 3'd7, 2'b11, 1'b1};
    if ({enable, state, mode, busy} !== exp9) begin
      errors++; $display("FAIL b2b_night got=%b want=%b", {enable, state, mode, busy}, exp9);
    end
    step;
    for (int i = 0; i < ct; i++) begin
      if (i == 0) begin modeReq = 2'b01; modeReqValid = 1'b1; end
      if (i == 1) modeReqValid = 1'b0;
      #1; checks++; exp9 = {3'b000, 3'd2, 2'b11, 1'b1};
      if ({enable, state, mode, busy} !== exp9) begin
        errors++; $display("FAIL b2b_clear2[%0d] got=%b want=%b", i, {enable, state, mode, busy}, exp9);
      end
      step;
    end
    #1; checks++; exp9 = {3'b010, 3'd3, 2'b01, 1'b1};
    if ({enable, state, mode, busy} !== exp9) begin
      errors++; $display("FAIL b2b_auto got=%b want=%b", {enable, state, mode, busy}, exp9);
    end
    step;
    #1; checks++; exp9 = {3'b010, 3'd3, 2'b01, 1'b0};
    if ({enable, state, mode, busy} !== exp9) begin
      errors++; $display("FAIL b2b_discard got=%b want=%b", {enable, state, mode, busy}, exp9);
    end
  endtask

  // Reset asserted mid-cycle while waiting for a safe point.
  task automatic test_reset_in_wait;
    int ct;
    ct = 1 + int'($urandom_range(0, 9));
    autoState = 3'd6;
    modeReq = 2'b10; modeReqValid = 1'b1;
    step;
    modeReqValid = 1'b0;
    step; step; step;
    reset = 1'b1;
    #1; checks++; exp9 = {3'b000, 3'd2, 2'b01, 1'b1};
    if ({enable, state, mode, busy} !== exp9) begin
      errors++; $display("FAIL rwait_async got=%b want=%b", {enable, state, mode, busy}, exp9);
    end
    step;
    reset = 1'b0; clearTime = 7'(ct);
    for (int i = 0; i < ct; i++) begin
      #1; checks++; exp9 = {3'b000, 3'd2, 2'b01, 1'b1};
      if ({enable, state, mode, busy} !== exp9) begin
        errors++; $display("FAIL rwait_clear[%0d] got=%b want=%b", i, {enable, state, mode, busy}, exp9);
      end
      step;
    end
    for (int i = 0; i < 3; i++) begin
      #1; checks++; exp9 = {3'b010, 3'd6, 2'b01, 1'b0};
      if ({enable, state, mode, busy} !== exp9) begin
        errors++; $display("FAIL rwait_run[%0d] got=%b want=%b", i, {enable, state, mode, busy}, exp9);
      end
      step;
    end
  endtask

  initial begin
    test_reset;
    test_safe_point;
    test_timeout;
    test_night_flash;
    test_night_exit;
    test_back_to_back;
    test_reset_in_wait;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
